wb_drain_controller: RTL and testbench

//  Read-side (pop) engine for the Wishbone FIFO. Drains a show-ahead FIFO head

---
 rtl/wishbone_pkg.sv | 15 +
 rtl/wb_outstanding_ctr.sv | 35 +++
 rtl/wb_drain_controller.sv | 102 ++++++++++
 tb/tb_wb_drain_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_pkg.sv
// Shared Wishbone types and helpers for the FIFO drain engine.
package wishbone_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    ERROR = 2'd2
  } wb_drain_state_t;

  // Counter width able to hold 0..n inclusive.
  function automatic int OUT_W(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/wb_outstanding_ctr.sv
// Up/down counter of accepted-but-unacknowledged Wishbone requests.
module wb_outstanding_ctr
  import wishbone_pkg::*;
#(
  parameter int MAX = 4,
  localparam int CW = OUT_W(MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic [CW-1:0] next
);

  // next excludes clr so the caller sees the pure accept/done arithmetic.
  always_comb begin
    next = count;
    if (inc && !dec)
      next = count + CW'(1);
    else if (!inc && dec)
      next = count - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else
      count <= next;
  end

endmodule

// File: rtl/wb_drain_controller.sv
// Pops a show-ahead FIFO head onto a pipelined Wishbone B4 device as single-beat writes.
module wb_drain_controller
  import wishbone_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] src_data_i,
  input  logic                  src_empty_i,
  output logic                  src_pop_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic                  wb_stall_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  output logic                  err_o,
  input  logic                  err_clr_i
);

  localparam int CW = OUT_W(MAX_OUTSTANDING);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  wb_drain_state_t state, state_nx;
  logic [CW-1:0]   outstanding, next_out;
  logic            accept, done, load, stb_nx, ctr_clr;

  assign accept = wb_stb_o && !wb_stall_i;
  assign done   = wb_cyc_o && (wb_ack_i || wb_err_i) && (outstanding != '0);

  // A new word may only be presented once the current strobe is taken.
  assign load = (state != ERROR) && !src_empty_i && (!wb_stb_o || accept) &&
                (next_out < MAX_C);

  assign src_pop_o = load && !rst_i;
  assign stb_nx    = load || (wb_stb_o && !accept);
  assign wb_we_o   = wb_cyc_o;
  assign ctr_clr   = (state_nx == ERROR);

  wb_outstanding_ctr #(.MAX(MAX_OUTSTANDING)) u_ctr (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (accept),
    .dec   (done),
    .clr   (ctr_clr),
    .count (outstanding),
    .next  (next_out)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (load) state_nx = BUS;
      BUS: begin
        if (wb_err_i && wb_cyc_o)
          state_nx = ERROR;
        else if (!stb_nx && next_out == '0)
          state_nx = IDLE;
      end
      ERROR: if (err_clr_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_dat_o <= '0;
      err_o    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx == ERROR) begin
        // Pending strobe and unacked words are dropped on a bus error.
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        err_o    <= 1'b1;
      end else begin
        wb_cyc_o <= (state_nx == BUS);
        wb_stb_o <= stb_nx;
        if (load)
          wb_dat_o <= src_data_i;
        if (state == ERROR)
          err_o <= 1'b0;
      end
    end
  end

  a_out_max: assert property (@(posedge clk_i) disable iff (rst_i)
    outstanding <= MAX_C);
  a_stall_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    wb_stb_o && wb_stall_i && !(wb_err_i && wb_cyc_o) |=> $stable(wb_dat_o) && wb_stb_o);
  a_stb_cyc: assert property (@(posedge clk_i) disable iff (rst_i)
    wb_stb_o |-> wb_cyc_o);
  a_idle_zero: assert property (@(posedge clk_i) disable iff (rst_i)
    !wb_cyc_o |-> outstanding == '0);

endmodule

// File: tb/tb_wb_drain_controller.sv
// Directed bench for wb_drain_controller with a queue-backed FIFO source.
module tb_wb_drain_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src_data;
  logic       src_empty;
  logic       src_pop;
  logic       wb_cyc, wb_stb, wb_we;
  logic [7:0] wb_dat;
  logic       wb_stall, wb_ack, wb_err;
  logic       err_o;
  logic       err_clr;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  logic [7:0] acc_log[$];
  int   pops = 0;
  int   accepts = 0;
  logic pop_seen, acc_seen;
  logic auto_ack = 1'b0;
  int   any_act;
  int   p0, a0;

  always #5 clk = ~clk;

  wb_drain_controller #(.DATA_WIDTH(8), .MAX_OUTSTANDING(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .src_data_i  (src_data),
    .src_empty_i (src_empty),
    .src_pop_o   (src_pop),
    .wb_cyc_o    (wb_cyc),
    .wb_stb_o    (wb_stb),
    .wb_we_o     (wb_we),
    .wb_dat_o    (wb_dat),
    .wb_stall_i  (wb_stall),
    .wb_ack_i    (wb_ack),
    .wb_err_i    (wb_err),
    .err_o       (err_o),
    .err_clr_i   (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh_src();
    src_empty = (q.size() == 0);
    if (q.size() != 0) src_data = q[0];
    else src_data = 8'h00;
  endtask

  // One clock cycle: sample settled handshakes, cross the edge, update stimulus.
  task automatic tick();
    #4;
    pop_seen = src_pop;
    acc_seen = wb_stb && !wb_stall;
    if (pop_seen && q.size() != 0) begin
      pops++;
      void'(q.pop_front());
    end
    if (acc_seen) begin
      accepts++;
      acc_log.push_back(wb_dat);
    end
    @(posedge clk);
    #1;
    refresh_src();
    if (auto_ack) wb_ack = acc_seen;
  endtask

  initial begin
    rst = 1'b1; wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; err_clr = 1'b0;
    src_empty = 1'b0; src_data = 8'h55;

    // Reset state, including a non-empty source while reset is held
    repeat (2) @(posedge clk);
    #3;
    check("rst_pop", src_pop, 0);
    check("rst_cyc", wb_cyc, 0);
    check("rst_stb", wb_stb, 0);
    check("rst_err", err_o, 0);
    check("rst_dat", wb_dat, 0);
    refresh_src();
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: idle with empty source
    any_act = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wb_cyc || wb_stb || pop_seen) any_act++;
    end
    check("t1_activity", any_act, 0);
    check("t1_err", err_o, 0);

    // 2: three words, ack one cycle after accept
    q = '{8'h11, 8'h22, 8'h33}; refresh_src(); auto_ack = 1'b1; p0 = pops;
    tick(); check("t2_stb0", wb_stb, 1); check("t2_dat0", wb_dat, 8'h11); check("t2_we", wb_we, 1);
    tick(); check("t2_dat1", wb_dat, 8'h22);
    tick(); check("t2_dat2", wb_dat, 8'h33);
    tick(); check("t2_stb_off", wb_stb, 0); check("t2_cyc_hold", wb_cyc, 1);
    tick(); check("t2_cyc_off", wb_cyc, 0);
    check("t2_pops", pops - p0, 3);

    // 3: six words with acks withheld
    repeat (2) tick();
    auto_ack = 1'b0; wb_ack = 1'b0; acc_log.delete(); a0 = accepts;
    q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5}; refresh_src();
    repeat (8) tick();
    check("t3_accepts", accepts - a0, 4);
    check("t3_stb", wb_stb, 0);
    check("t3_left", q.size(), 2);
    check("t3_cyc", wb_cyc, 1);
    check("t3_out", dut.outstanding, 4);
    wb_ack = 1'b1;
    repeat (6) tick();
    wb_ack = 1'b0;
    check("t3_accepts_all", accepts - a0, 6);
    check("t3_cyc_off", wb_cyc, 0);
    check("t3_empty", q.size(), 0);
    check("t3_word4", acc_log[4], 8'hA4);
    check("t3_word5", acc_log[5], 8'hA5);

    // 4: stall held five cycles on 0x22
    tick();
    q = '{8'h21, 8'h22, 8'h23}; refresh_src(); auto_ack = 1'b1; a0 = accepts;
    tick(); tick();
    check("t4_dat", wb_dat, 8'h22);
    wb_stall = 1'b1; any_act = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (pop_seen) any_act++;
      check("t4_hold_dat", wb_dat, 8'h22);
      check("t4_hold_stb", wb_stb, 1);
    end
    check("t4_no_pop", any_act, 0);
    wb_stall = 1'b0;
    tick();
    check("t4_pop6", pop_seen, 1);
    check("t4_next", wb_dat, 8'h23);
    check("t4_accepts", accepts - a0, 2);
    repeat (4) tick();
    check("t4_cyc_off", wb_cyc, 0);

    // 5: error on the second response of a burst
    auto_ack = 1'b0; wb_ack = 1'b0;
    q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5}; refresh_src(); p0 = pops;
    tick(); tick();
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0; wb_err = 1'b1;
    tick();
    wb_err = 1'b0;
    check("t5_err", err_o, 1);
    check("t5_cyc", wb_cyc, 0);
    check("t5_stb", wb_stb, 0);
    check("t5_out", dut.outstanding, 0);
    check("t5_pops", pops - p0, 4);
    any_act = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (pop_seen || wb_cyc) any_act++;
    end
    check("t5_frozen", any_act, 0);
    check("t5_err_sticky", err_o, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t5_err_clr", err_o, 0);
    tick();
    check("t5_resume_dat", wb_dat, 8'hB4);
    check("t5_resume_stb", wb_stb, 1);
    auto_ack = 1'b1;
    repeat (6) tick();
    check("t5_cyc_off", wb_cyc, 0);

    // 6: reset asserted between edges mid-burst
    q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3}; refresh_src(); p0 = pops;
    tick(); tick();
    check("t6_pre_dat", wb_dat, 8'hC1);
    #2 rst = 1'b1;
    #1;
    check("t6_cyc", wb_cyc, 0);
    check("t6_stb", wb_stb, 0);
    check("t6_pop", src_pop, 0);
    check("t6_dat", wb_dat, 0);
    check("t6_out", dut.outstanding, 0);
    tick(); tick();
    check("t6_pops_in_rst", pops - p0, 2);
    rst = 1'b0; auto_ack = 1'b0; wb_ack = 1'b0; auto_ack = 1'b1;
    tick();
    check("t6_restart_dat", wb_dat, 8'hC2);
    check("t6_restart_stb", wb_stb, 1);
    repeat (5) tick();
    check("t6_cyc_off", wb_cyc, 0);
    check("t6_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
